compressor_input_fifo: RTL and testbench

Packet-aware first-word-fall-through FIFO between the compressor controller and the compression engine. Beats arrive from the controller's `infifo_push` strobe together with the 256-bit burst, its end-of-packet marker and the controller's per-packet compression decision. The FIFO drives `full` back to the controller as its `infifo_full` input. The engine drains entries through a valid/ready handshake, and the FIFO reports occupancy, complete-packet count and a sticky overflow error.

---
 rtl/compressor_input_fifo.sv | 121 ++++++++++++
 tb/tb_compressor_input_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/compressor_input_fifo.sv
// compressor_input_fifo: packet-aware first-word-fall-through FIFO between the
// compressor controller and the compression engine. Tracks occupancy, the number
// of stored end-of-packet beats, and a sticky overflow flag.
module compressor_input_fifo #(
    parameter int unsigned BURST_WIDTH = 256,
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned AF_MARGIN   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [BURST_WIDTH-1:0] push_data,
    input  logic                   push_last,
    input  logic                   push_compress,
    output logic                   full,
    output logic                   almost_full,
    output logic                   pop_valid,
    input  logic                   pop_ready,
    output logic [BURST_WIDTH-1:0] pop_data,
    output logic                   pop_last,
    output logic                   pop_compress,
    output logic [DEPTH_LOG2:0]    level,
    output logic [DEPTH_LOG2:0]    pkt_count,
    output logic                   overflow,
    input  logic                   clear_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;
    localparam int unsigned EW    = BURST_WIDTH + 2;

    logic [EW-1:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [LW-1:0]         pkt_q, pkt_d;
    logic                  ovf_q, ovf_d;
    logic                  push_acc;
    logic                  pop_acc;
    logic                  pkt_inc;
    logic                  pkt_dec;
    logic [EW-1:0]         head;

    // Status flags decode only from registered occupancy.
    assign full        = (level_q == LW'(DEPTH));
    assign almost_full = (level_q >= LW'(DEPTH - AF_MARGIN));
    assign pop_valid   = (level_q != '0);
    assign level       = level_q;
    assign pkt_count   = pkt_q;
    assign overflow    = ovf_q;

    // Head entry, gated so stale array contents never leak out.
    assign head         = mem_q[rd_ptr_q];
    assign pop_data     = pop_valid ? head[BURST_WIDTH-1:0] : '0;
    assign pop_last     = pop_valid & head[BURST_WIDTH];
    assign pop_compress = pop_valid & head[BURST_WIDTH+1];

    // Next-state for pointers, counters and the sticky error.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        pkt_d    = pkt_q;
        ovf_d    = ovf_q;
        push_acc = push & ~full;
        pop_acc  = pop_valid & pop_ready;
        pkt_inc  = push_acc & push_last;
        pkt_dec  = pop_acc & pop_last;

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end

        if (push_acc && !pop_acc) begin
            level_d = level_q + LW'(1);
        end else if (pop_acc && !push_acc) begin
            level_d = level_q - LW'(1);
        end

        if (pkt_inc && !pkt_dec) begin
            pkt_d = pkt_q + LW'(1);
        end else if (pkt_dec && !pkt_inc) begin
            pkt_d = pkt_q - LW'(1);
        end

        // An overflowing push wins over a simultaneous clear.
        if (push && full) begin
            ovf_d = 1'b1;
        end else if (clear_err) begin
            ovf_d = 1'b0;
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            pkt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            pkt_q    <= pkt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= {push_compress, push_last, push_data};
        end
    end

endmodule

// File: tb/tb_compressor_input_fifo.sv
// Self-checking bench for compressor_input_fifo: directed steps plus random
// traffic compared against a queue-based behavioural model.
module tb_compressor_input_fifo;

    logic         clk;
    logic         reset;
    logic         push;
    logic [255:0] push_data;
    logic         push_last;
    logic         push_compress;
    logic         full;
    logic         almost_full;
    logic         pop_valid;
    logic         pop_ready;
    logic [255:0] pop_data;
    logic         pop_last;
    logic         pop_compress;
    logic [4:0]   level;
    logic [4:0]   pkt_count;
    logic         overflow;
    logic         clear_err;

    int checks;
    int failures;

    // Model: queue of {compress, last, data}, plus the sticky error bit.
    logic [257:0] mq[$];
    logic         m_ovf;

    compressor_input_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .push_data    (push_data),
        .push_last    (push_last),
        .push_compress(push_compress),
        .full         (full),
        .almost_full  (almost_full),
        .pop_valid    (pop_valid),
        .pop_ready    (pop_ready),
        .pop_data     (pop_data),
        .pop_last     (pop_last),
        .pop_compress (pop_compress),
        .level        (level),
        .pkt_count    (pkt_count),
        .overflow     (overflow),
        .clear_err    (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int           n;
        logic [255:0] ed;
        logic         el;
        logic         ec;
        n  = 0;
        foreach (mq[i]) if (mq[i][256]) n++;
        ed = '0;
        el = 1'b0;
        ec = 1'b0;
        if (mq.size() != 0) begin
            ed = mq[0][255:0];
            el = mq[0][256];
            ec = mq[0][257];
        end
        chk({tag, ".level"},     256'(level),        256'(mq.size()));
        chk({tag, ".pkt_count"}, 256'(pkt_count),    256'(n));
        chk({tag, ".full"},      256'(full),         256'(mq.size() == 16));
        chk({tag, ".almost"},    256'(almost_full),  256'(mq.size() >= 14));
        chk({tag, ".valid"},     256'(pop_valid),    256'(mq.size() != 0));
        chk({tag, ".data"},      pop_data,           ed);
        chk({tag, ".last"},      256'(pop_last),     256'(el));
        chk({tag, ".compress"},  256'(pop_compress), 256'(ec));
        chk({tag, ".overflow"},  256'(overflow),     256'(m_ovf));
    endtask

    function automatic logic [255:0] rand_beat();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // One clock: drive inputs, model the edge, then check #1 after it.
    task automatic step(input string tag, input logic p, input logic [255:0] d,
                        input logic l, input logic c, input logic r, input logic ce);
        bit was_full;
        bit pa;
        bit pp;
        push          = p;
        push_data     = d;
        push_last     = l;
        push_compress = c;
        pop_ready     = r;
        clear_err     = ce;
        @(posedge clk);
        was_full = (mq.size() == 16);
        pa = p && !was_full;
        pp = r && (mq.size() != 0);
        if (p && was_full) m_ovf = 1'b1;
        else if (ce)       m_ovf = 1'b0;
        if (pp) void'(mq.pop_front());
        if (pa) mq.push_back({c, l, d});
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input string tag);
        while (mq.size() != 0) step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [255:0] a5;
        a5            = {32{8'hA5}};
        checks        = 0;
        failures      = 0;
        m_ovf         = 1'b0;
        reset         = 1'b1;
        push          = 1'b1;
        push_data     = a5;
        push_last     = 1'b1;
        push_compress = 1'b1;
        pop_ready     = 1'b1;
        clear_err     = 1'b0;

        // Reset held with push asserted: everything stays zero.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_push_held");
        @(negedge clk);
        push   = 1'b0;
        reset  = 1'b0;

        // Single beat visible one edge after push.
        step("a5_push", 1'b1, a5, 1'b1, 1'b1, 1'b0, 1'b0);
        step("a5_pop", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Fill with 0..15, then overflow with 16.
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 256'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        step("push_full", 1'b1, 256'(16), 1'b1, 1'b0, 1'b0, 1'b0);
        idle("overflow_hold");
        drain("drain_in_order");
        step("clear1", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Full: push and pop together, pop wins, push dropped.
        for (int i = 0; i < 16; i++) step("refill", 1'b1, rand_beat(), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        step("full_push_pop", 1'b1, rand_beat(), 1'b1, 1'b1, 1'b1, 1'b0);
        step("full_refill", 1'b1, rand_beat(), 1'b0, 1'b0, 1'b0, 1'b0);
        step("ovf_and_clear", 1'b1, rand_beat(), 1'b0, 1'b0, 1'b0, 1'b1);
        step("clear2", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        drain("drain2");

        // Push while empty with pop_ready: accepted, no pop.
        step("empty_push_ready", 1'b1, rand_beat(), 1'b0, 1'b1, 1'b1, 1'b0);
        step("hold1", 1'b1, rand_beat(), 1'b1, 1'b0, 1'b0, 1'b0);
        step("hold2", 1'b1, rand_beat(), 1'b0, 1'b0, 1'b0, 1'b0);

        // Streaming at level 3 for 40 cycles.
        for (int i = 0; i < 40; i++) step("stream", 1'b1, rand_beat(), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
        drain("drain3");

        // Packet counting.
        for (int i = 1; i <= 12; i++) step("pkts", 1'b1, 256'(i), 1'(i % 4 == 0), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step("pkt_pop", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("pkt_both_last", 1'b1, 256'(99), 1'b1, 1'b0, 1'b1, 1'b0);
        drain("drain4");

        // Random traffic, push-biased to reach full and overflow.
        for (int i = 0; i < 300; i++)
            step("random", 1'($urandom_range(0, 9) < 6), rand_beat(), 1'($urandom),
                 1'($urandom), 1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 19) == 0));
        drain("drain5");
        step("clear3", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Mid-operation asynchronous reset at level 9.
        for (int i = 0; i < 9; i++) step("fill9", 1'b1, rand_beat(), 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        #1;
        check_all("async_reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step("post_reset_push", 1'b1, a5, 1'b0, 1'b1, 1'b0, 1'b0);
        step("post_reset_pop", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
